// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller slice.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_WAIT,
    D_RESP,
    I_REQ,
    I_WAIT
  } state_t;

  localparam int WORD_OFFSET_BITS = 2;
  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_ctrl_ibuf.sv
// One-entry tagged instruction buffer; the tag is the word address of the stored instruction.
module mem_ctrl_ibuf
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               fill,
  input  logic [ADDR_W-WORD_OFFSET_BITS-1:0] fill_tag,
  input  logic [DATA_W-1:0]                  fill_data,
  input  logic [ADDR_W-1:0]                  lookup_addr,
  input  logic                               invalidate,
  output logic                               hit,
  output logic [DATA_W-1:0]                  data
);

  logic                               buf_valid;
  logic [ADDR_W-WORD_OFFSET_BITS-1:0] buf_tag;
  logic [DATA_W-1:0]                  buf_data;

  // Invalidate takes precedence over a fill arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || invalidate) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (fill) begin
      buf_valid <= 1'b1;
      buf_tag   <= fill_tag;
      buf_data  <= fill_data;
    end
  end

  assign hit  = buf_valid && (buf_tag == lookup_addr[ADDR_W-1:WORD_OFFSET_BITS]);
  assign data = buf_data;

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates CPU data and fetch ports onto one external word bus, with a
// one-entry instruction buffer and a saturating response timeout.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                TIMEOUT      = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(DEFAULT_TIMEOUT_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_instr_addr,
  output logic [DATA_W-1:0] cpu_instr_data,
  output logic              cpu_instr_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_valid,
  output logic              err_timeout,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_ready,
  input  logic              ext_rvalid,
  input  logic [DATA_W-1:0] ext_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept;
  logic              in_wait;
  logic              rsp_to;
  logic              ibuf_fill;
  logic              ibuf_hit;
  logic [DATA_W-1:0] ibuf_fill_data;

  assign accept         = ext_req && ext_ready;
  assign in_wait        = (state == D_WAIT) || (state == I_WAIT);
  assign rsp_to         = in_wait && !ext_rvalid && (wait_cnt == CNT_MAX);
  assign ibuf_fill      = (state == I_WAIT) && (ext_rvalid || rsp_to);
  assign ibuf_fill_data = ext_rvalid ? ext_rdata : TIMEOUT_DATA;
  assign cpu_valid      = (state == D_RESP);

  mem_ctrl_ibuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .fill       (ibuf_fill),
    .fill_tag   (ext_addr[ADDR_W-1:WORD_OFFSET_BITS]),
    .fill_data  (ibuf_fill_data),
    .lookup_addr(cpu_instr_addr),
    .invalidate (1'b0),
    .hit        (ibuf_hit),
    .data       (cpu_instr_data)
  );

  assign cpu_instr_valid = ibuf_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Data accesses always win over a fetch miss; neither preempts an access in flight.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cpu_wr || cpu_rd) next_state = D_REQ;
        else if (!ibuf_hit)   next_state = I_REQ;
      end
      D_REQ:  if (accept) next_state = ext_we ? D_RESP : D_WAIT;
      D_WAIT: if (ext_rvalid || rsp_to) next_state = D_RESP;
      D_RESP: next_state = IDLE;
      I_REQ:  if (accept) next_state = I_WAIT;
      I_WAIT: if (ext_rvalid || rsp_to) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are loaded only when leaving IDLE, so they stay frozen through any ready stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_req     <= 1'b0;
      ext_we      <= 1'b0;
      ext_addr    <= '0;
      ext_wdata   <= '0;
      cpu_rd_data <= '0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      err_timeout <= rsp_to;
      if (state == IDLE && next_state == D_REQ) begin
        ext_req   <= 1'b1;
        ext_we    <= cpu_wr;
        ext_addr  <= {cpu_addr[ADDR_W-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
        ext_wdata <= cpu_wr_data;
      end else if (state == IDLE && next_state == I_REQ) begin
        ext_req  <= 1'b1;
        ext_we   <= 1'b0;
        ext_addr <= {cpu_instr_addr[ADDR_W-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
      end else if (accept) begin
        ext_req <= 1'b0;
      end

      if (in_wait) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (state == D_WAIT) begin
        if (ext_rvalid)  cpu_rd_data <= ext_rdata;
        else if (rsp_to) cpu_rd_data <= TIMEOUT_DATA;
      end
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller sitting directly downstream of the CPU top level.
- Consumes the CPU instruction-fetch port and the data load/store port (rd/wr/addr/wr_data), and returns instruction data, read data and a completion pulse.
- Arbitrates both CPU ports onto a single external word-wide memory bus with request/ready and response-valid handshakes.
- Adds a one-entry tagged instruction buffer and a response timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- TIMEOUT, 255, maximum cycles to wait for ext_rvalid after a request is accepted (counter width = $clog2(TIMEOUT+1)).
- TIMEOUT_DATA, 32'hDEADBEEF, data returned when a read times out.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cpu_instr_addr  in  ADDR_W  fetch address.
- cpu_instr_data  out  DATA_W  fetched instruction (from buffer).
- cpu_instr_valid  out  1  cpu_instr_data matches cpu_instr_addr.
- cpu_addr  in  ADDR_W  data address.
- cpu_wr_data  in  DATA_W  store data.
- cpu_wr  in  1  store request (level, held until cpu_valid).
- cpu_rd  in  1  load request (level, held until cpu_valid).
- cpu_rd_data  out  DATA_W  load data, valid with cpu_valid.
- cpu_valid  out  1  one-cycle data-access completion pulse.
- err_timeout  out  1  one-cycle pulse when any read times out.
- ext_req  out  1  external request.
- ext_we  out  1  1 = write, 0 = read.
- ext_addr  out  ADDR_W  word-aligned address.
- ext_wdata  out  DATA_W  write data.
- ext_ready  in  1  external side accepts request this cycle.
- ext_rvalid  in  1  read response valid.
- ext_rdata  in  DATA_W  read response data.

Behaviour:

Reset values:
- All outputs 0, FSM in IDLE, buffer invalid, timeout counter 0.
- Reset mid-transaction aborts to IDLE with no cpu_valid pulse.
- The external device shares rst, so no stale responses exist after reset.

Addressing:
- ext_addr = {addr[ADDR_W-1:2], 2'b00}; addr[1:0] are ignored.

Request handshake:
- ext_req, ext_we, ext_addr and ext_wdata are registered and held stable while ext_req=1 and ext_ready=0.
- The request is accepted on the cycle where ext_req and ext_ready are both 1.
- ext_req deasserts the following cycle.

FSM states: IDLE, D_REQ, D_WAIT, D_RESP, I_REQ, I_WAIT.

From IDLE:
- If cpu_wr or cpu_rd, go to D_REQ. Data has priority over fetch.
- cpu_wr and cpu_rd both high: treated as a write; cpu_rd is ignored.
- Otherwise, on instruction-buffer miss, go to I_REQ.

Data path:
- D_REQ, write accepted: go to D_RESP. Writes are posted; no ext_rvalid is expected.
- D_REQ, read accepted: go to D_WAIT; timeout counter cleared.
- D_WAIT, ext_rvalid: register cpu_rd_data <= ext_rdata, then go to D_RESP.
- D_WAIT, counter reaches TIMEOUT: cpu_rd_data <= TIMEOUT_DATA, err_timeout pulse, go to D_RESP.
- D_RESP: cpu_valid=1 for exactly one cycle, then IDLE.
- The CPU advances on cpu_valid; request inputs sampled in the next IDLE belong to the next access.

Read latency:
- Total = 1 (IDLE to D_REQ) + ready wait + response wait + 1 (D_RESP).
- Minimum read latency, with ext_ready and ext_rvalid each asserted the cycle after request/acceptance, is 4 cycles from cpu_rd to cpu_valid.

Instruction path:
- Hit: cpu_instr_valid = buf_valid && buf_tag == cpu_instr_addr[ADDR_W-1:2]. This is combinational.
- I_REQ/I_WAIT follow the same handshake as the data path.
- ext_rvalid fills the buffer (tag = word address captured at request time), then IDLE.
- Timeout fills the buffer with TIMEOUT_DATA and pulses err_timeout.
- If cpu_instr_addr changes during I_WAIT (branch), the fill completes with the old tag; the resulting miss refetches.

Simultaneous events and boundaries:
- A data request arriving during I_REQ/I_WAIT waits until that fetch completes; there is no preemption.
- ext_rvalid outside D_WAIT/I_WAIT is ignored.
- A late response after a timeout is unsupported; the external device must not produce one.
- The timeout counter saturates at TIMEOUT and is cleared on every entry to a WAIT state.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state_t enum (IDLE, D_REQ, D_WAIT, D_RESP, I_REQ, I_WAIT);
  - WORD_OFFSET_BITS = 2;
  - default TIMEOUT_DATA constant.
- Sub-module mem_ctrl_ibuf is the one-entry tagged instruction buffer.
  - Inputs: fill strobe, fill tag, fill data, lookup address, invalidate.
  - Outputs: hit, data.
- FSM, counter and external-port registers stay in mem_ctrl.

Test Plan:
1. Reset then idle, no requests -> all outputs 0, ext_req=0.
2. Store: cpu_wr=1, cpu_addr=0x1003, wr_data=0xA5A5_0001, ext_ready held 0 for 3 cycles -> ext_req, ext_we=1, ext_addr=0x1000 stable for 4 cycles; cpu_valid pulses once, 1 cycle after acceptance.
3. Load: cpu_rd=1, addr 0x2000, ext_ready immediate, ext_rdata=0x1234_5678 after 2 cycles -> cpu_rd_data=0x12345678 with a one-cycle cpu_valid.
4. Fetch: miss at 0x40, response 0xCAFE_0000 -> cpu_instr_valid=1 with data 0xCAFE0000; a repeat of 0x40 causes no new ext_req; 0x44 causes a new fetch.
5. Collision: cpu_rd and a fetch miss asserted in the same IDLE cycle -> data request issued first, fetch issued after cpu_valid.
6. Timeout: load with ext_rvalid never asserted, TIMEOUT=255 -> err_timeout and cpu_valid pulse; cpu_rd_data=0xDEADBEEF.
